matricial_scanner: RTL and testbench

MATRICIAL_SCANNER -- requirements
Module: matricial_scanner

---
 rtl/keypad_pkg.sv | 39 +++
 rtl/sync_2ff.sv | 27 ++
 rtl/matricial_scanner.sv | 139 +++++++++++++
 tb/tb_matricial_scanner.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// The key map is indexed [row][column]; '*' and '#' get the two codes above 'D'.
package keypad_pkg;

    typedef logic [3:0] key_code_t;

    localparam key_code_t KEY_STAR = 4'hE;
    localparam key_code_t KEY_HASH = 4'hF;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StHeld,
        StRelease
    } scan_state_t;

    localparam key_code_t KEY_MAP [4][4] = '{
        '{4'h1,     4'h2, 4'h3,     4'hA},
        '{4'h4,     4'h5, 4'h6,     4'hB},
        '{4'h7,     4'h8, 4'h9,     4'hC},
        '{KEY_STAR, 4'h0, KEY_HASH, 4'hD}
    };

    // True when exactly one row line is pulled low.
    function automatic logic single_low(input logic [3:0] lin);
        return ($countones(~lin) == 1);
    endfunction

    // Index of the low row; only meaningful when single_low() holds.
    function automatic logic [1:0] low_index(input logic [3:0] lin);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!lin[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, with a selectable reset value.
module sync_2ff #(
    parameter int unsigned     WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/matricial_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column strobe, debounces a single
// pressed key, reports it once with a one-cycle valid pulse and tracks its release.
module matricial_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES     = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 20
) (
    input  logic      clk,
    input  logic      rst,
    output logic [3:0] matricial_col,
    input  logic [3:0] matricial_lin,
    output key_code_t key_code,
    output logic      key_valid,
    output logic      key_pressed
);

    localparam int unsigned SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);

    logic [3:0]        w_lin_s;
    logic              w_one_low;
    logic [1:0]        w_low_idx;
    logic              w_pat_ok;
    logic              w_row_hi;
    logic [DB_W-1:0]   w_db_inc;
    logic [3:0]        w_col_oh_next;

    scan_state_t       r_state;
    logic [1:0]        r_col;
    logic [3:0]        r_col_oh;
    logic [1:0]        r_row;
    logic [SCAN_W-1:0] r_scan_cnt;
    logic [DB_W-1:0]   r_db_cnt;
    key_code_t         r_key_code;
    logic              r_key_valid;
    logic              r_key_pressed;

    sync_2ff #(
        .WIDTH       (4),
        .RESET_VALUE (4'b1111)
    ) u_sync_lin (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (matricial_lin),
        .o_q   (w_lin_s)
    );

    assign w_one_low     = single_low(w_lin_s);
    assign w_low_idx     = low_index(w_lin_s);
    assign w_pat_ok      = (w_lin_s == ~(4'b0001 << r_row));
    assign w_row_hi      = w_lin_s[r_row];
    assign w_col_oh_next = {r_col_oh[2:0], r_col_oh[3]};

    // Saturating increment: the counter parks at DB_MAX instead of wrapping.
    assign w_db_inc = (r_db_cnt == DB_MAX) ? r_db_cnt : r_db_cnt + DB_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StScan;
            r_col         <= 2'd0;
            r_col_oh      <= 4'b1110;
            r_row         <= 2'd0;
            r_scan_cnt    <= '0;
            r_db_cnt      <= '0;
            r_key_code    <= 4'h0;
            r_key_valid   <= 1'b0;
            r_key_pressed <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            unique case (r_state)
                StScan: begin
                    if (r_scan_cnt == SCAN_LAST) begin
                        r_scan_cnt <= '0;
                        if (w_one_low) begin
                            r_row    <= w_low_idx;
                            r_db_cnt <= '0;
                            r_state  <= StDebounce;
                        end else begin
                            r_col    <= r_col + 2'd1;
                            r_col_oh <= w_col_oh_next;
                        end
                    end else begin
                        r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
                    end
                end
                StDebounce: begin
                    if (!w_pat_ok) begin
                        r_db_cnt   <= '0;
                        r_scan_cnt <= '0;
                        r_col      <= r_col + 2'd1;
                        r_col_oh   <= w_col_oh_next;
                        r_state    <= StScan;
                    end else if (w_db_inc == DB_MAX) begin
                        r_key_code    <= KEY_MAP[r_row][r_col];
                        r_key_valid   <= 1'b1;
                        r_key_pressed <= 1'b1;
                        r_db_cnt      <= '0;
                        r_state       <= StHeld;
                    end else begin
                        r_db_cnt <= w_db_inc;
                    end
                end
                StHeld: begin
                    // Only the latched row matters; other keys on this column are ignored.
                    if (w_row_hi) begin
                        r_db_cnt <= '0;
                        r_state  <= StRelease;
                    end
                end
                StRelease: begin
                    if (!w_row_hi) begin
                        r_db_cnt <= '0;
                        r_state  <= StHeld;
                    end else if (w_db_inc == DB_MAX) begin
                        r_key_pressed <= 1'b0;
                        r_db_cnt      <= '0;
                        r_scan_cnt    <= '0;
                        r_col         <= r_col + 2'd1;
                        r_col_oh      <= w_col_oh_next;
                        r_state       <= StScan;
                    end else begin
                        r_db_cnt <= w_db_inc;
                    end
                end
                default: r_state <= StScan;
            endcase
        end
    end

    assign matricial_col = r_col_oh;
    assign key_code      = r_key_code;
    assign key_valid     = r_key_valid;
    assign key_pressed   = r_key_pressed;

endmodule

// File: tb/tb_matricial_scanner.sv
// Self-checking bench for matricial_scanner: a keypad model closes row/column contacts,
// a monitor tallies valid pulses, and directed plus random presses are checked.
module tb_matricial_scanner;

    localparam int SCAN = 4;
    localparam int DB   = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col;
    logic [3:0] lin;
    logic [3:0] code;
    logic       valid;
    logic       pressed;

    logic [15:0] key_down = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    int n_valid    = 0;
    int onehot_err = 0;
    int pulse_err  = 0;
    int col_hits [4] = '{0, 0, 0, 0};
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    matricial_scanner #(
        .SCAN_CYCLES     (SCAN),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .matricial_col (col),
        .matricial_lin (lin),
        .key_code      (code),
        .key_valid     (valid),
        .key_pressed   (pressed)
    );

    // Keypad: a closed key connects its row to its column.
    always_comb begin
        lin = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_down[r*4+c] && !col[c]) lin[r] = 1'b0;
    end

    always @(negedge clk) begin
        if ($countones(~col) != 1) onehot_err <= onehot_err + 1;
        if (!rst) begin
            if (valid) n_valid <= n_valid + 1;
            if (valid && prev_valid) pulse_err <= pulse_err + 1;
            for (int c = 0; c < 4; c++)
                if (!col[c]) col_hits[c] <= col_hits[c] + 1;
        end
        prev_valid <= valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] exp_code(input int r, input int c);
        if (c == 3) return 4'(10 + r);
        if (r == 3) return (c == 0) ? 4'hE : ((c == 1) ? 4'h0 : 4'hF);
        return 4'(3 * r + c + 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bounce(input int idx, input int n);
        repeat (n) begin
            @(negedge clk);
            key_down[idx] = 1'($urandom % 2);
        end
    endtask

    task automatic press_release(input int r, input int c, input int b_in, input int hold,
                                 input int b_out, input string tag);
        int v0;
        int idx;
        v0  = n_valid;
        idx = r * 4 + c;
        bounce(idx, b_in);
        @(negedge clk);
        key_down[idx] = 1'b1;
        repeat (hold) @(negedge clk);
        check({tag, " pressed"}, 32'(pressed), 32'd1);
        check({tag, " pulses"}, 32'(n_valid - v0), 32'd1);
        check({tag, " code"}, 32'(code), 32'(exp_code(r, c)));
        bounce(idx, b_out);
        @(negedge clk);
        key_down[idx] = 1'b0;
        repeat (10) @(negedge clk);
        check({tag, " still pressed"}, 32'(pressed), 32'd1);
        repeat (DB + 30) @(negedge clk);
        check({tag, " released"}, 32'(pressed), 32'd0);
        check({tag, " single pulse"}, 32'(n_valid - v0), 32'd1);
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        repeat (SCAN - 1) @(negedge clk);
        check({tag, " col held"}, 32'(col), 32'h0000000E);
        @(negedge clk);
        check({tag, " col advanced"}, 32'(col), 32'h0000000D);
    endtask

    initial begin
        int v0;
        int hits0 [4];
        int seen;

        repeat (3) @(negedge clk);
        check("reset col", 32'(col), 32'h0000000E);
        check("reset code", 32'(code), 32'd0);
        check("reset valid", 32'(valid), 32'd0);
        check("reset pressed", 32'(pressed), 32'd0);
        release_reset("first");

        press_release(1, 1, 0, 100, 0, "key5");
        press_release(3, 2, 6, 100, 0, "hash");

        // Bounce alone must not register.
        v0 = n_valid;
        bounce(0, 15);
        @(negedge clk);
        key_down = '0;
        repeat (60) @(negedge clk);
        check("bounce only", 32'(n_valid - v0), 32'd0);

        press_release(0, 0, 0, 500, 5, "key1 long");

        // Two keys on the same column: ignored, scanning continues everywhere.
        v0 = n_valid;
        hits0 = col_hits;
        key_down[0*4+1] = 1'b1;
        key_down[2*4+1] = 1'b1;
        repeat (200) @(negedge clk);
        check("dual pulses", 32'(n_valid - v0), 32'd0);
        seen = 0;
        for (int c = 0; c < 4; c++) if (col_hits[c] > hits0[c]) seen++;
        check("dual all columns", 32'(seen), 32'd4);
        key_down = '0;
        repeat (20) @(negedge clk);

        // Reset in the middle of debouncing key D.
        v0 = n_valid;
        key_down[3*4+3] = 1'b1;
        seen = 0;
        for (int i = 0; i < 100 && seen == 0; i++) begin
            @(negedge clk);
            if (col == 4'b0111) seen = 1;
        end
        check("D column reached", 32'(seen), 32'd1);
        repeat (3 + 10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort col", 32'(col), 32'h00000007 ^ 32'h9);
        check("abort code", 32'(code), 32'd0);
        check("abort pressed", 32'(pressed), 32'd0);
        check("abort valid", 32'(valid), 32'd0);
        check("abort no pulse", 32'(n_valid - v0), 32'd0);
        repeat (2) @(negedge clk);
        key_down = '0;
        release_reset("after abort");
        repeat (100) @(negedge clk);
        check("abort none after", 32'(n_valid - v0), 32'd0);

        press_release(0, 0, 0, 100, 0, "seq1");
        press_release(0, 1, 0, 100, 0, "seq2");
        press_release(0, 2, 0, 100, 0, "seq3");
        press_release(1, 0, 0, 100, 0, "seq4");

        for (int k = 0; k < 6; k++) begin
            int r;
            int c;
            r = int'($urandom_range(3, 0));
            c = int'($urandom_range(3, 0));
            press_release(r, c, int'($urandom_range(6, 0)), int'($urandom_range(160, 80)),
                          int'($urandom_range(5, 0)), $sformatf("rand%0d r%0d c%0d", k, r, c));
        end

        check("col one-hot", 32'(onehot_err), 32'd0);
        check("valid one cycle", 32'(pulse_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
